// File: rtl/alu_pkg.sv
// Shared ALU datapath types. The divide-by-zero flag field exists only when
// DIV_ZERO_CHK_EN is defined.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
`ifdef DIV_ZERO_CHK_EN
    logic              err;
`endif
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
  } div_result_t;

endpackage

// File: rtl/div_result_collector_if.sv
// Divider-side capture inputs, result handshake and status of the collector.
// The master modport is the collector itself; slave is its environment.
interface div_result_collector_if #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  import alu_pkg::*;

  logic              div_done;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] div_r;
  logic [DATA_W-1:0] div_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] out_r;
  logic              out_err;
  logic              ovf_clr;
  logic              overflow;
  logic [CNT_W-1:0]  count;

  modport master (
    input  div_done, div_q, div_r, div_b, out_ready, ovf_clr,
    output out_valid, out_q, out_r, out_err, overflow, count
  );

  modport slave (
    output div_done, div_q, div_r, div_b, out_ready, ovf_clr,
    input  out_valid, out_q, out_r, out_err, overflow, count
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on rdata_o
// whenever the FIFO is not empty. A push into a full FIFO is accepted only
// together with a pop.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only observed once count_q marks it valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/div_result_collector.sv
// Captures one divider result per rising edge of div_done into a FWFT FIFO and
// raises a sticky overflow on drops. DIV_ZERO_CHK_EN adds a divide-by-zero flag.
module div_result_collector
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  div_result_collector_if.master div_if
);

  localparam int ENTRY_W = $bits(div_result_t);

  logic               done_q;
  logic               overflow_q, overflow_d;
  logic               cap, pop, push, drop;
  logic               full, empty;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head_raw;
  div_result_t        entry_in;
  div_result_t        head;

  // done_q resets high so a result already pending at reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b1;
    else        done_q <= div_if.div_done;
  end

  assign cap  = div_if.div_done & ~done_q;
  assign pop  = ~empty & div_if.out_ready;
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  always_comb begin
    entry_in   = '0;
    entry_in.q = div_if.div_q;
    entry_in.r = div_if.div_r;
`ifdef DIV_ZERO_CHK_EN
    if (div_if.div_b == '0) begin
      entry_in.err = 1'b1;
      entry_in.q   = '1;
      entry_in.r   = '0;
    end
`endif
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (entry_in),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head = head_raw;

  // Outputs are gated to zero while empty so unwritten storage never shows.
  assign div_if.out_valid = ~empty;
  assign div_if.out_q     = empty ? '0 : head.q;
  assign div_if.out_r     = empty ? '0 : head.r;
  assign div_if.count     = count;

`ifdef DIV_ZERO_CHK_EN
  assign div_if.out_err = ~empty & head.err;
`else
  logic unused_div_b;
  assign unused_div_b   = ^div_if.div_b;
  assign div_if.out_err = 1'b0;
`endif

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (div_if.ovf_clr) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign div_if.overflow = overflow_q;

endmodule

// File: tb/tb_div_result_collector.sv
// Scoreboard bench for div_result_collector: stimulus queues expected results,
// a negedge monitor checks every accepted head entry in order.
module tb_div_result_collector;
  import alu_pkg::*;

  typedef struct packed {
    logic       err;
    logic [7:0] q;
    logic [7:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  div_result_collector_if #(.DEPTH(2)) bus ();

  div_result_collector #(.DEPTH(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t expect_div(input logic [7:0] q, input logic [7:0] r, input logic [7:0] b);
    exp_t e;
    e.err = 1'b0;
    e.q   = q;
    e.r   = r;
`ifdef DIV_ZERO_CHK_EN
    if (b == 8'd0) begin
      e.err = 1'b1;
      e.q   = 8'hFF;
      e.r   = 8'h00;
    end
`else
    if (b == 8'd0) e.err = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: an entry is consumed at the next posedge whenever valid & ready.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got q=%0h r=%0h expected no entry", bus.out_q, bus.out_r);
      end else begin
        mon_e = sb_q.pop_front();
        check("pop_q", 32'(bus.out_q), 32'(mon_e.q));
        check("pop_r", 32'(bus.out_r), 32'(mon_e.r));
        check("pop_err", 32'(bus.out_err), 32'(mon_e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input logic [7:0] q, input logic [7:0] r, input logic [7:0] b, input bit accept);
    bus.div_done = 1'b1;
    bus.div_q    = q;
    bus.div_r    = r;
    bus.div_b    = b;
    if (accept) sb_q.push_back(expect_div(q, r, b));
  endtask

  task automatic pulse(input logic [7:0] q, input logic [7:0] r, input logic [7:0] b, input bit accept);
    set_div(q, r, b, accept);
    step();
    bus.div_done = 1'b0;
    step();
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 20; i++) begin
      if (bus.count == '0) break;
      step();
    end
    check(name, 32'(bus.count), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e0;
    bus.div_done  = 1'b0;
    bus.div_q     = '0;
    bus.div_r     = '0;
    bus.div_b     = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;

    #12;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_q", 32'(bus.out_q), 0);
    check("rst_r", 32'(bus.out_r), 0);
    check("rst_err", 32'(bus.out_err), 0);
    #5 rst_n = 1'b1;
    step();

    // 7/3 with done held 5 cycles: one entry, valid one clock after capture.
    bus.out_ready = 1'b1;
    set_div(8'd2, 8'd1, 8'd3, 1'b1);
    check("t1_valid_before_edge", 32'(bus.out_valid), 0);
    step();
    check("t1_valid_latency", 32'(bus.out_valid), 1);
    check("t1_count", 32'(bus.count), 1);
    check("t1_head_q", 32'(bus.out_q), 2);
    step();
    check("t1_count_after_pop", 32'(bus.count), 0);
    step();
    step();
    step();
    check("t1_no_recapture", 32'(bus.count), 0);
    bus.div_done = 1'b0;
    step();

    // Stalled consumer: third result dropped, overflow sticky until cleared.
    bus.out_ready = 1'b0;
    pulse(8'd2, 8'd1, 8'd3, 1'b1);
    pulse(8'd28, 8'd4, 8'd7, 1'b1);
    pulse(8'd1, 8'd0, 8'd9, 1'b0);
    check("t2_count_full", 32'(bus.count), 2);
    check("t2_overflow", 32'(bus.overflow), 1);
    check("t2_head_q", 32'(bus.out_q), 2);
    check("t2_head_r", 32'(bus.out_r), 1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("t2_ovf_cleared", 32'(bus.overflow), 0);
    check("t2_count_kept", 32'(bus.count), 2);

    // Full with pop and capture in the same cycle: push accepted.
    bus.out_ready = 1'b1;
    set_div(8'd5, 8'd0, 8'd3, 1'b1);
    step();
    check("t3_count_same", 32'(bus.count), 2);
    check("t3_no_overflow", 32'(bus.overflow), 0);
    bus.div_done  = 1'b0;
    bus.out_ready = 1'b0;
    step();

    // Clear and a new drop in the same cycle: set wins.
    bus.ovf_clr = 1'b1;
    set_div(8'd3, 8'd0, 8'd3, 1'b0);
    step();
    check("t3_set_wins", 32'(bus.overflow), 1);
    bus.ovf_clr  = 1'b0;
    bus.div_done = 1'b0;
    step();
    bus.out_ready = 1'b1;
    wait_empty("t3_drain");
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("t3_ovf_cleared", 32'(bus.overflow), 0);

    // Back-to-back done pulses one cycle apart.
    set_div(8'd3, 8'd1, 8'd3, 1'b1);
    step();
    bus.div_done = 1'b0;
    step();
    set_div(8'd3, 8'd2, 8'd6, 1'b1);
    step();
    bus.div_done = 1'b0;
    step();
    wait_empty("t4_drain");
    check("t4_no_overflow", 32'(bus.overflow), 0);

    // Divisor zero: flagged and forced with the feature, raw otherwise.
    bus.out_ready = 1'b0;
    set_div(8'h12, 8'h34, 8'd0, 1'b1);
    e0 = expect_div(8'h12, 8'h34, 8'd0);
    step();
    check("t5_err", 32'(bus.out_err), 32'(e0.err));
    check("t5_q", 32'(bus.out_q), 32'(e0.q));
    check("t5_r", 32'(bus.out_r), 32'(e0.r));
    bus.div_done  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    wait_empty("t5_drain");

    // Asynchronous flush mid-operation, then done held high across release.
    bus.out_ready = 1'b0;
    pulse(8'd1, 8'd0, 8'd9, 1'b1);
    pulse(8'd4, 8'd1, 8'd5, 1'b1);
    check("t6_count_full", 32'(bus.count), 2);
    set_div(8'd7, 8'd0, 8'd1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.out_valid), 0);
    check("t6_async_count", 32'(bus.count), 0);
    sb_q.delete();
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    step();
    check("t6_no_capture_release", 32'(bus.count), 0);
    check("t6_valid_release", 32'(bus.out_valid), 0);
    bus.div_done  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    pulse(8'd7, 8'd0, 8'd1, 1'b1);
    wait_empty("t6_drain");

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_result_collector.md
Name: div_result_collector

Overview:
Downstream stage of the 8-bit sequential divider in the ALU datapath. It watches the divider's level `done` and captures the quotient/remainder once per completed division. Results are held in a small first-word-fall-through FIFO and presented to the ALU result/writeback logic over a valid/ready handshake. This decouples the divider from a consumer that may stall.

Parameters:
- DATA_W, 8: width of quotient and remainder.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- div_done  input  1  divider done level; high while result valid.
- div_q  input  DATA_W  divider quotient.
- div_r  input  DATA_W  divider remainder.
- div_b  input  DATA_W  divisor currently applied to divider; used only by the optional feature.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- out_q  output  DATA_W  head quotient.
- out_r  output  DATA_W  head remainder.
- out_err  output  1  head entry divide-by-zero flag.
- ovf_clr  input  1  synchronous clear of overflow.
- overflow  output  1  sticky: a result was dropped.
- count  output  CNT_W  current occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all FIFO pointers and count = 0; out_valid = 0; out_q = 0; out_r = 0; out_err = 0; overflow = 0; done_d = 1.
  - Because done_d resets to 1, a div_done already high at reset release is never captured.
- Edge detect: `cap = div_done & ~done_d`, with `done_d <= div_done` every cycle.
  - Exactly one capture per low→high transition of div_done, regardless of how long done stays high.
- Capture sampling: the capture samples div_q, div_r (and div_b) in the same cycle cap is high.
- Latency: the entry is written at that edge. out_valid rises in the next cycle, so capture-to-out_valid is 1 clk.
- Handshake:
  - pop = out_valid & out_ready. The head advances on pop.
  - out_q, out_r and out_err are combinationally driven from the head entry (FWFT). They are stable while out_valid & ~out_ready.
  - out_valid = (count != 0).
- Push rules:
  - push = cap & (count < DEPTH, or pop in same cycle).
  - Full with cap and pop in the same cycle: push accepted, count unchanged.
  - Full with cap and no pop: entry dropped, overflow set to 1, FIFO contents untouched.
- Simultaneous push and pop:
  - When not full: count unchanged.
  - When empty with cap: no pop is possible (out_valid = 0), so count goes to 1.
- Counter arithmetic:
  - count += push − pop, never exceeding DEPTH and never going below 0.
  - Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Overflow:
  - Sticky until ovf_clr or reset.
  - ovf_clr and a new drop in the same cycle: overflow stays 1 (set wins).
- Reset mid-operation: FIFO flushed immediately (asynchronous). Any pending divider result is discarded unless div_done subsequently toggles low→high.
- Without the optional feature, out_err is tied to 0.

Optional Feature:
- Macro: DIV_ZERO_CHK_EN.
- Defined:
  - On capture, err = (div_b == 0). Stored with the entry.
  - When err = 1, the stored quotient is forced to {DATA_W{1'b1}} and the stored remainder to 0, regardless of div_q/div_r.
- Undefined:
  - div_b is ignored.
  - out_err = 0 constant.
  - No err storage bit.

Decomposition:
- Shared package alu_pkg: DATA_W constant (8) and a packed struct `div_result_t {logic err; logic [DATA_W-1:0] q, r;}` used for FIFO entries.
- One natural sub-module: sync_fifo_fwft (parameterised width/depth, push/pop/count/full). The collector adds edge detect, overflow and err logic around it.

Test Plan:
- a=7, b=3, divider asserts done held 5 cycles → exactly one entry; out_valid high 1 clk after the rising edge; out_q=2, out_r=1; count=1; out_ready=1 pops it and count=0.
- out_ready=0, three divisions (7/3, 200/7, 9/9) → count=2; entries q=2,r=1 then q=28,r=4; third dropped; overflow=1. Pulse ovf_clr → overflow=0.
- Full FIFO with out_ready=1 on the same cycle as a new done rising edge → push accepted, count stays 2, order preserved, overflow stays 0.
- div_done high at rst_n release → no capture, count=0. Assert rst_n low with count=2 → out_valid=0 and count=0 asynchronously, before the next clk edge.
- With DIV_ZERO_CHK_EN defined: b=0, done edge → out_err=1, out_q=8'hFF, out_r=0. Without it: out_err=0 and raw q/r passed through.
- Back-to-back done pulses one cycle apart with out_ready=1 → two entries delivered in order, no drop.
